// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        SHOW = 2'd2
    } scan_state_t;

    localparam int              DIGIT_W = 4;
    localparam logic [3:0]      BCD_MAX = 4'd9;

endpackage

// File: rtl/scan_slot_counter.sv
// Per-slot cycle counter: counts 0..TICK_DIV-1 and flags the last dead and last slot cycle.
module scan_slot_counter #(
    parameter int TICK_DIV    = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic dead_last,
    output logic slot_last
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_END = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    assign dead_last = (cnt_reg == DEAD_END);
    assign slot_last = (cnt_reg == SLOT_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear || slot_last) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 7-segment scan controller with frame-coherent shadow value,
// dead-time between slots and optional leading-zero blanking.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic                          lz_blank,
    output logic [DIGIT_W-1:0]            bcd,
    output logic [NUM_DIGITS-1:0]         dig_en,
    output logic                          load_ack,
    output logic                          frame_done
);

    localparam int VW = DIGIT_W * NUM_DIGITS;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    scan_state_t state_reg, state_next;

    logic [IW-1:0]         idx_reg, idx_next;
    logic [VW-1:0]         shadow_reg, shadow_next;
    logic [VW-1:0]         pending_reg, pending_next;
    logic                  pend_flag_reg, pend_flag_next;
    logic                  load_ack_reg, load_ack_next;
    logic                  frame_done_reg, frame_done_next;
    logic [DIGIT_W-1:0]    bcd_reg, bcd_next;
    logic [NUM_DIGITS-1:0] dig_en_reg, dig_en_next;
    logic                  slot_blank_reg, slot_blank_next;

    logic cnt_clear;
    logic dead_last;
    logic slot_last;
    logic frame_end;

    scan_slot_counter #(
        .TICK_DIV    (TICK_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_slot_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cnt_clear),
        .dead_last (dead_last),
        .slot_last (slot_last)
    );

    // Digit view of the shadow value that will be in effect next cycle, plus
    // "this digit and every higher digit is zero" for leading-zero blanking.
    logic [DIGIT_W-1:0]    next_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] upper_zero;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign next_digit[gi] = shadow_next[gi*DIGIT_W +: DIGIT_W];
        assign upper_zero[gi] = ~|shadow_next[VW-1:gi*DIGIT_W];
    end

    assign frame_end = (state_reg == SHOW) && slot_last && (idx_reg == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        shadow_next     = shadow_reg;
        pending_next    = pending_reg;
        pend_flag_next  = pend_flag_reg;
        load_ack_next   = 1'b0;
        frame_done_next = 1'b0;
        cnt_clear       = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_clear = 1'b1;
                idx_next  = '0;
                // No frame to protect while idle: update the shadow directly.
                if (load) begin
                    shadow_next    = value;
                    pend_flag_next = 1'b0;
                    load_ack_next  = 1'b1;
                end else if (pend_flag_reg) begin
                    shadow_next    = pending_reg;
                    pend_flag_next = 1'b0;
                    load_ack_next  = 1'b1;
                end
                if (enable) begin
                    state_next = DEAD;
                end
            end
            DEAD, SHOW: begin
                if (!enable) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cnt_clear  = 1'b1;
                    if (load) begin
                        pending_next   = value;
                        pend_flag_next = 1'b1;
                    end
                end else begin
                    if (state_reg == DEAD && dead_last) begin
                        state_next = SHOW;
                    end
                    if (state_reg == SHOW && slot_last) begin
                        state_next = DEAD;
                        idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + IW'(1);
                    end
                    if (frame_end) begin
                        frame_done_next = 1'b1;
                        pend_flag_next  = 1'b0;
                        if (load) begin
                            shadow_next   = value;
                            load_ack_next = 1'b1;
                        end else if (pend_flag_reg) begin
                            shadow_next   = pending_reg;
                            load_ack_next = 1'b1;
                        end
                    end else if (load) begin
                        pending_next   = value;
                        pend_flag_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Digit code and blank decision are latched on slot entry so they hold for the whole slot.
    always_comb begin
        bcd_next        = bcd_reg;
        slot_blank_next = slot_blank_reg;
        dig_en_next     = '0;
        if (state_next == DEAD) begin
            bcd_next        = next_digit[idx_next];
            slot_blank_next = (next_digit[idx_next] > BCD_MAX) ||
                              (lz_blank && (idx_next != '0) && upper_zero[idx_next]);
        end
        if (state_next == SHOW && !slot_blank_next) begin
            dig_en_next = NUM_DIGITS'(1) << idx_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg        <= '0;
            shadow_reg     <= '0;
            pending_reg    <= '0;
            pend_flag_reg  <= 1'b0;
            load_ack_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            bcd_reg        <= '0;
            dig_en_reg     <= '0;
            slot_blank_reg <= 1'b0;
        end else begin
            idx_reg        <= idx_next;
            shadow_reg     <= shadow_next;
            pending_reg    <= pending_next;
            pend_flag_reg  <= pend_flag_next;
            load_ack_reg   <= load_ack_next;
            frame_done_reg <= frame_done_next;
            bcd_reg        <= bcd_next;
            dig_en_reg     <= dig_en_next;
            slot_blank_reg <= slot_blank_next;
        end
    end

    assign bcd        = bcd_reg;
    assign dig_en     = dig_en_reg;
    assign load_ack   = load_ack_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed scoreboard bench for display_scan_controller (4 digits, 8-cycle slots, 2 dead cycles).
module tb_display_scan_controller;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic        lz_blank;
    logic [3:0]  bcd;
    logic [3:0]  dig_en;
    logic        load_ack;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] bcd;
        logic [3:0] en;
        logic       fd;
        logic       ack;
    } slot_t;

    slot_t sb [$];

    display_scan_controller #(
        .NUM_DIGITS  (4),
        .TICK_DIV    (8),
        .DEAD_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .lz_blank   (lz_blank),
        .bcd        (bcd),
        .dig_en     (dig_en),
        .load_ack   (load_ack),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of one slot: shown code and enable pattern for digit i.
    task automatic push_slot(input int i, input logic [15:0] v, input logic lz,
                             input logic fd, input logic ack);
        slot_t      e;
        logic [3:0] d;
        logic       up_zero;
        d       = v[4*i +: 4];
        up_zero = 1'b1;
        for (int k = i; k < 4; k++) begin
            if (v[4*k +: 4] != 4'd0) up_zero = 1'b0;
        end
        e.bcd = d;
        e.en  = ((d > 4'd9) || (lz && i > 0 && up_zero)) ? 4'b0000 : (4'b0001 << i);
        e.fd  = fd;
        e.ack = ack;
        sb.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] v, input logic lz, input logic fd, input logic ack);
        for (int i = 0; i < 4; i++) begin
            push_slot(i, v, lz, (i == 0) ? fd : 1'b0, (i == 0) ? ack : 1'b0);
        end
    endtask

    // Checks ncyc cycles of the current slot against the next scoreboard entry;
    // optionally pulses load at slot cycles lc1/lc2.
    task automatic run_slot(input int ncyc, input int lc1, input logic [15:0] v1,
                            input int lc2, input logic [15:0] v2);
        slot_t e;
        chk("sb_empty", 32'(sb.size() == 0), 32'd0);
        if (sb.size() > 0) e = sb.pop_front();
        else               e = '0;
        $display("slot: bcd=%h dig_en=%b exp_bcd=%h exp_en=%b fd=%b ack=%b",
                 bcd, dig_en, e.bcd, e.en, frame_done, load_ack);
        for (int c = 0; c < ncyc; c++) begin
            chk("bcd", 32'(bcd), 32'(e.bcd));
            chk("dig_en", 32'(dig_en), (c < 2) ? 32'd0 : 32'(e.en));
            chk("frame_done", 32'(frame_done), (c == 0) ? 32'(e.fd) : 32'd0);
            chk("load_ack", 32'(load_ack), (c == 0) ? 32'(e.ack) : 32'd0);
            if (c == lc1) begin
                load  = 1'b1;
                value = v1;
            end else if (c == lc2) begin
                load  = 1'b1;
                value = v2;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        lz_blank = 1'b0;
        #1;
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_dig_en", 32'(dig_en), 32'd0);
        chk("rst_load_ack", 32'(load_ack), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load while idle: acknowledged on the following cycle.
        value = 16'h1234;
        load  = 1'b1;
        tick();
        chk("idle_ack", 32'(load_ack), 32'd1);
        chk("idle_dig_en", 32'(dig_en), 32'd0);
        load = 1'b0;
        tick();
        chk("idle_ack_drop", 32'(load_ack), 32'd0);

        // Scan two frames of 1234.
        enable = 1'b1;
        tick();
        push_frame(16'h1234, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) run_slot(8, -1, 16'h0, -1, 16'h0);
        push_frame(16'h1234, 1'b0, 1'b1, 1'b0);
        for (int s = 0; s < 4; s++) run_slot(8, -1, 16'h0, -1, 16'h0);

        // Two mid-frame loads: display unchanged, last one wins at the boundary.
        push_frame(16'h1234, 1'b0, 1'b1, 1'b0);
        run_slot(8, -1, 16'h0, -1, 16'h0);
        run_slot(8, 3, 16'h9876, 5, 16'h1111);
        run_slot(8, -1, 16'h0, -1, 16'h0);
        run_slot(8, -1, 16'h0, -1, 16'h0);

        // New frame shows 1111; a load on the exact boundary cycle goes straight in.
        push_frame(16'h1111, 1'b0, 1'b1, 1'b1);
        for (int s = 0; s < 3; s++) run_slot(8, -1, 16'h0, -1, 16'h0);
        run_slot(8, 7, 16'h4321, -1, 16'h0);

        // 4321 has no zero digits, so turning lz_blank on here does not alter it.
        lz_blank = 1'b1;
        push_frame(16'h4321, 1'b1, 1'b1, 1'b1);
        run_slot(8, -1, 16'h0, -1, 16'h0);
        run_slot(8, -1, 16'h0, -1, 16'h0);
        run_slot(8, 2, 16'h0050, -1, 16'h0);
        run_slot(8, -1, 16'h0, -1, 16'h0);

        push_frame(16'h0050, 1'b1, 1'b1, 1'b1);
        run_slot(8, -1, 16'h0, -1, 16'h0);
        run_slot(8, 4, 16'h0000, -1, 16'h0);
        run_slot(8, -1, 16'h0, -1, 16'h0);
        run_slot(8, -1, 16'h0, -1, 16'h0);

        push_frame(16'h0000, 1'b1, 1'b1, 1'b1);
        for (int s = 0; s < 4; s++) run_slot(8, -1, 16'h0, -1, 16'h0);

        // Slot 0 is already latched; digit 0 is never zero-blanked either way.
        lz_blank = 1'b0;
        push_frame(16'h0000, 1'b0, 1'b1, 1'b0);
        run_slot(8, 3, 16'h1A23, -1, 16'h0);
        for (int s = 0; s < 3; s++) run_slot(8, -1, 16'h0, -1, 16'h0);

        // Invalid code in digit 2 blanks only that slot.
        push_frame(16'h1A23, 1'b0, 1'b1, 1'b1);
        for (int s = 0; s < 4; s++) run_slot(8, -1, 16'h0, -1, 16'h0);

        // Disable in the middle of slot 1 SHOW, with a load arriving at the same time.
        push_slot(0, 16'h1A23, 1'b0, 1'b1, 1'b0);
        push_slot(1, 16'h1A23, 1'b0, 1'b0, 1'b0);
        run_slot(8, -1, 16'h0, -1, 16'h0);
        run_slot(4, -1, 16'h0, -1, 16'h0);
        chk("pre_disable_dig_en", 32'(dig_en), 32'b0010);
        chk("pre_disable_bcd", 32'(bcd), 32'h2);
        enable = 1'b0;
        value  = 16'h5555;
        load   = 1'b1;
        tick();
        load = 1'b0;
        chk("disable_dig_en", 32'(dig_en), 32'd0);
        chk("disable_ack", 32'(load_ack), 32'd0);
        tick();
        chk("idle_pending_ack", 32'(load_ack), 32'd1);
        chk("idle_pending_dig_en", 32'(dig_en), 32'd0);
        tick();
        chk("idle_pending_ack_drop", 32'(load_ack), 32'd0);

        // Re-enable restarts from digit 0 with the pending value applied.
        enable = 1'b1;
        tick();
        push_frame(16'h5555, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) run_slot(8, -1, 16'h0, -1, 16'h0);

        // Asynchronous reset in DEAD: outputs clear without a clock edge.
        chk("pre_reset_bcd", 32'(bcd), 32'h5);
        chk("pre_reset_frame_done", 32'(frame_done), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bcd", 32'(bcd), 32'd0);
        chk("async_rst_dig_en", 32'(dig_en), 32'd0);
        chk("async_rst_load_ack", 32'(load_ack), 32'd0);
        chk("async_rst_frame_done", 32'(frame_done), 32'd0);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_dig_en", 32'(dig_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
